wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writeback stage sitting directly upstream of the integer register file; it owns that file's single write port.
- Merges two result producers into one write per cycle:
  - the single-cycle ALU path, which can be stalled but has no ready handshake;
  - the long-latency LSU/mul-div path, which uses valid/ready and is buffered in a small FIFO.
- Drives the register file's active-low write enable, plus a pending-rd bitmap that issue logic uses for hazard checks.

Parameters:
- DATA_W, 64, result/register data width.
- DEPTH, 2, LSU result FIFO entries (power of two, >=2).
- STARVE_MAX, 4, consecutive ALU wins allowed while the FIFO is non-empty before the ALU is stalled one cycle.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid_i  in  1  ALU result present; held stable while alu_stall_o=1.
- alu_rd_idx_i  in  5  ALU destination register.
- alu_data_i  in  DATA_W  ALU result.
- alu_stall_o  out  1  ALU result not accepted this cycle; upstream holds.
- lsu_valid_i  in  1  long-path result valid.
- lsu_ready_o  out  1  FIFO can accept.
- lsu_rd_idx_i  in  5  long-path destination register.
- lsu_data_i  in  DATA_W  long-path result.
- wen_o  out  1  register-file write enable, ACTIVE LOW.
- rd_idx_o  out  5  write index.
- rd_wdata_o  out  DATA_W  write data.
- rd_pending_o  out  32  bit i=1 if a FIFO entry targets xi; bit 0 always 0.

Behaviour:
- Reset (async, rst_n=0):
  - wen_o=1, rd_idx_o=0, rd_wdata_o=0.
  - FIFO empty, starve counter=0.
  - Combinational outputs then give lsu_ready_o=1, alu_stall_o=0, rd_pending_o=0.
  - Reset mid-operation discards buffered entries, with no write issued.
- LSU enqueue:
  - lsu_ready_o = (count < DEPTH), derived from registered count only.
  - Handshake when lsu_valid_i & lsu_ready_o at a rising edge; entry written at the tail.
  - When full, ready=0 even if a drain occurs that cycle.
- Per-cycle selection (combinational):
  - alu_stall_o = fifo_nonempty & (starve_cnt == STARVE_MAX).
  - If alu_valid_i & !alu_stall_o: ALU is selected.
  - Else if fifo_nonempty: FIFO head is selected and popped at the edge.
  - Else: nothing selected.
- Output register, loaded every edge:
  - Selected with rd != 0: wen_o <= 0, rd_idx_o <= rd, rd_wdata_o <= data.
  - Selected with rd == 0: the source is still consumed/popped, but wen_o <= 1 (write dropped).
  - Nothing selected: wen_o <= 1; rd_idx_o and rd_wdata_o hold their previous values.
- Latency:
  - ALU: sampled at edge E0, wen_o low in the cycle after E0 (1 cycle).
  - LSU with no contention: handshake at E0, selected in the cycle after, wen_o low after E1 (2 cycles).
- Starve counter:
  - Increments (saturating at STARVE_MAX) each edge the ALU is selected while the FIFO is non-empty.
  - Clears on any FIFO pop, or whenever the FIFO is empty.
  - Consequence: at most STARVE_MAX consecutive ALU writes precede a forced drain.
- Simultaneous enqueue and pop: allowed when not full; count unchanged; pointers wrap mod DEPTH.
- rd_pending_o:
  - OR of one-hot(rd) over valid FIFO entries, computed from registered state.
  - Bit 0 is masked.
  - The entry sitting in the output register is not pending: the register file forwards it while wen_o=0.
- Ordering:
  - No WAW reordering check here. Issue logic must not send an ALU write to a register with rd_pending_o set.
  - FIFO entries drain in arrival order.

Test Plan:
- Reset, then ALU x5=0x1234 for one cycle -> wen_o=0, rd_idx_o=5, rd_wdata_o=0x1234 the next cycle; wen_o=1 after that.
- LSU x7=0xAA, no ALU traffic -> rd_pending_o[7]=1 for one cycle; two edges after the handshake, wen_o=0 with idx 7, data 0xAA; pending clears.
- Continuous ALU valid and two LSU entries queued (STARVE_MAX=4) -> 4 ALU writes, then alu_stall_o=1 for one cycle and the LSU head writes, then 4 more ALU writes, then the second LSU entry.
- FIFO full (2 entries) with lsu_valid_i held -> lsu_ready_o=0 until a pop; the third entry is accepted on the edge after the pop. Every issued write must appear in FIFO arrival order.
- ALU write to x0 with data 0xFFFF -> wen_o stays 1, no stall. LSU write to x0 -> pops, rd_pending_o stays 0, no write.
- rst_n driven low asynchronously mid-clock with 2 entries queued -> wen_o=1 immediately; after release, no buffered writes appear and lsu_ready_o=1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - writeback arbiter producer/regfile bus bundle
`timescale 1ns/1ps

interface wb_arbiter_if #(
  parameter int DATA_W = 64
);
  // ALU producer (no ready, stall back-pressure only)
  logic              alu_valid_i;
  logic [4:0]        alu_rd_idx_i;
  logic [DATA_W-1:0] alu_data_i;
  logic              alu_stall_o;

  // long-latency producer (valid/ready into the result FIFO)
  logic              lsu_valid_i;
  logic              lsu_ready_o;
  logic [4:0]        lsu_rd_idx_i;
  logic [DATA_W-1:0] lsu_data_i;

  // register-file write port and hazard bitmap
  logic              wen_o;
  logic [4:0]        rd_idx_o;
  logic [DATA_W-1:0] rd_wdata_o;
  logic [31:0]       rd_pending_o;

  // arbiter side
  modport slave (
    input  alu_valid_i, alu_rd_idx_i, alu_data_i,
    output alu_stall_o,
    input  lsu_valid_i, lsu_rd_idx_i, lsu_data_i,
    output lsu_ready_o,
    output wen_o, rd_idx_o, rd_wdata_o, rd_pending_o
  );

  // producer / register-file side
  modport master (
    output alu_valid_i, alu_rd_idx_i, alu_data_i,
    input  alu_stall_o,
    output lsu_valid_i, lsu_rd_idx_i, lsu_data_i,
    input  lsu_ready_o,
    input  wen_o, rd_idx_o, rd_wdata_o, rd_pending_o
  );
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter owning the integer register-file write port
`timescale 1ns/1ps

module wb_arbiter #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_arbiter_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  // result FIFO storage and bookkeeping
  logic [4:0]        r_fifo_rd   [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic [SW-1:0]     r_starve;

  // registered write port
  logic              r_wen;
  logic [4:0]        r_rd_idx;
  logic [DATA_W-1:0] r_wdata;

  logic              w_nonempty;
  logic              w_ready;
  logic              w_stall;
  logic              w_push;
  logic              w_pop;
  logic              w_sel_alu;
  logic              w_sel_valid;
  logic [4:0]        w_sel_rd;
  logic [DATA_W-1:0] w_sel_data;
  logic [31:0]       w_pending;

  // Ready and stall come only from registered state so neither producer
  // sees a combinational path through the other.
  assign w_nonempty = (r_count != '0);
  assign w_ready    = (r_count < DEPTH_C);
  assign w_stall    = w_nonempty && (r_starve == STARVE_C);
  assign w_push     = bus.lsu_valid_i && w_ready;
  assign w_sel_alu  = bus.alu_valid_i && !w_stall;
  assign w_pop      = !w_sel_alu && w_nonempty;

  // pick the source for this cycle's write
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    if (w_sel_alu) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.alu_rd_idx_i;
      w_sel_data  = bus.alu_data_i;
    end else if (w_pop) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_fifo_rd[r_rd_ptr];
      w_sel_data  = r_fifo_data[r_rd_ptr];
    end
  end

  // FIFO payload: no reset needed, validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= bus.lsu_rd_idx_i;
      r_fifo_data[r_wr_ptr] <= bus.lsu_data_i;
    end
  end

  // FIFO pointers and occupancy; reset drops every buffered entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Count consecutive ALU wins over a waiting FIFO head; any drain, or an
  // empty FIFO, restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (!w_nonempty || w_pop) begin
      r_starve <= '0;
    end else if (w_sel_alu && (r_starve != STARVE_C)) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  // Write port register: x0 targets are consumed but never written, and an
  // idle cycle leaves index/data untouched to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen    <= 1'b1;
      r_rd_idx <= '0;
      r_wdata  <= '0;
    end else if (w_sel_valid && (w_sel_rd != 5'd0)) begin
      r_wen    <= 1'b0;
      r_rd_idx <= w_sel_rd;
      r_wdata  <= w_sel_data;
    end else begin
      r_wen    <= 1'b1;
    end
  end

  // Pending bitmap over live FIFO entries only; the entry already in the
  // write register is forwarded by the register file, so it is excluded.
  always_comb begin
    logic [PW-1:0] off;
    off       = '0;
    w_pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - r_rd_ptr;
      if ({1'b0, off} < r_count) begin
        w_pending[r_fifo_rd[i]] = 1'b1;
      end
    end
    w_pending[0] = 1'b0;
  end

  assign bus.alu_stall_o  = w_stall;
  assign bus.lsu_ready_o  = w_ready;
  assign bus.wen_o        = r_wen;
  assign bus.rd_idx_o     = r_rd_idx;
  assign bus.rd_wdata_o   = r_wdata;
  assign bus.rd_pending_o = w_pending;

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard bench for the writeback arbiter
`timescale 1ns/1ps

module tb_wb_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } wr_t;

  logic clk;
  logic rst_n;
  logic mon_en;
  int   n_tests;
  int   n_fail;
  wr_t  alu_q[$];
  wr_t  lsu_q[$];

  wb_arbiter_if #(.DATA_W(64)) bus ();

  wb_arbiter #(.DATA_W(64), .DEPTH(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_lsu_rd(input logic [4:0] rd);
    return rd inside {5'd7, 5'd8, 5'd9, 5'd12, 5'd13, 5'd14, 5'd20, 5'd21, 5'd22};
  endfunction

  // observed writes popped against the per-producer expected streams
  always @(negedge clk) begin
    wr_t  e;
    logic has;
    if (mon_en && rst_n && (bus.wen_o == 1'b0)) begin
      if (is_lsu_rd(bus.rd_idx_o)) begin
        has = (lsu_q.size() != 0);
        check("lsu_sb_avail", 64'(has), 64'd1);
        if (has) begin
          e = lsu_q.pop_front();
          check("lsu_wr_idx", 64'(bus.rd_idx_o), 64'(e.rd));
          check("lsu_wr_data", bus.rd_wdata_o, e.data);
        end
      end else begin
        has = (alu_q.size() != 0);
        check("alu_sb_avail", 64'(has), 64'd1);
        if (has) begin
          e = alu_q.pop_front();
          check("alu_wr_idx", 64'(bus.rd_idx_o), 64'(e.rd));
          check("alu_wr_data", bus.rd_wdata_o, e.data);
        end
      end
    end
  end

  // one cycle of stimulus: drive at the falling edge, check combinational
  // handshake outputs, and record what must later be written
  task automatic cyc(input logic av, input logic [4:0] ard, input logic [63:0] ad,
                     input logic lv, input logic [4:0] lrd, input logic [63:0] ld,
                     input logic exp_stall, input logic exp_ready, input logic track);
    wr_t e;
    @(negedge clk);
    bus.alu_valid_i  = av;
    bus.alu_rd_idx_i = ard;
    bus.alu_data_i   = ad;
    bus.lsu_valid_i  = lv;
    bus.lsu_rd_idx_i = lrd;
    bus.lsu_data_i   = ld;
    #1;
    check("alu_stall", 64'(bus.alu_stall_o), 64'(exp_stall));
    check("lsu_ready", 64'(bus.lsu_ready_o), 64'(exp_ready));
    if (track) begin
      if (av && !exp_stall && (ard != 5'd0)) begin
        e.rd = ard; e.data = ad; alu_q.push_back(e);
      end
      if (lv && exp_ready && (lrd != 5'd0)) begin
        e.rd = lrd; e.data = ld; lsu_q.push_back(e);
      end
    end
  endtask

  task automatic idle(input logic exp_ready);
    cyc(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0, exp_ready, 1'b1);
  endtask

  initial begin
    int k;
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b1;
    rst_n   = 1'b0;
    bus.alu_valid_i  = 1'b0;
    bus.alu_rd_idx_i = '0;
    bus.alu_data_i   = '0;
    bus.lsu_valid_i  = 1'b0;
    bus.lsu_rd_idx_i = '0;
    bus.lsu_data_i   = '0;
    repeat (3) @(negedge clk);
    check("rst_wen", 64'(bus.wen_o), 64'd1);
    check("rst_rd_idx", 64'(bus.rd_idx_o), 64'd0);
    check("rst_wdata", bus.rd_wdata_o, 64'd0);
    check("rst_ready", 64'(bus.lsu_ready_o), 64'd1);
    check("rst_stall", 64'(bus.alu_stall_o), 64'd0);
    check("rst_pending", 64'(bus.rd_pending_o), 64'd0);
    rst_n = 1'b1;

    // single ALU write, one-cycle latency
    cyc(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    check("t1_wen_low", 64'(bus.wen_o), 64'd0);
    idle(1'b1);
    check("t1_wen_high", 64'(bus.wen_o), 64'd1);

    // single LSU write, two-cycle latency with pending visible in between
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'hAA, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    check("t2_pending7", 64'(bus.rd_pending_o), 64'h80);
    check("t2_wen_wait", 64'(bus.wen_o), 64'd1);
    idle(1'b1);
    check("t2_wen_low", 64'(bus.wen_o), 64'd0);
    check("t2_idx", 64'(bus.rd_idx_o), 64'd7);
    check("t2_pending_clr", 64'(bus.rd_pending_o), 64'd0);
    idle(1'b1);
    check("t2_wen_high", 64'(bus.wen_o), 64'd1);

    // starvation limit: continuous ALU, two LSU entries queued
    k = 0;
    for (int c = 0; c < 12; c++) begin
      logic st;
      logic rdy;
      st  = (c == 5) || (c == 10);
      rdy = !(c >= 2 && c <= 5);
      cyc(1'b1, 5'd10, 64'h100 + 64'(k),
          (c < 2), (c == 0) ? 5'd8 : 5'd9, (c == 0) ? 64'hB1 : 64'hB2,
          st, rdy, 1'b1);
      if (c == 6) check("t3_drain_idx", 64'(bus.rd_idx_o), 64'd8);
      if (c == 11) check("t3_drain2_idx", 64'(bus.rd_idx_o), 64'd9);
      if (!st) k++;
    end
    idle(1'b1);
    idle(1'b1);

    // full FIFO with lsu_valid held: third entry waits for the pop
    k = 0;
    for (int c = 0; c < 9; c++) begin
      logic [4:0]  lrd;
      logic [63:0] ld;
      logic rdy;
      lrd = (c == 0) ? 5'd12 : (c == 1) ? 5'd13 : 5'd14;
      ld  = (c == 0) ? 64'hC1 : (c == 1) ? 64'hC2 : 64'hC3;
      rdy = (c <= 1) || (c == 6) || (c == 8);
      cyc((c < 7), 5'd11, 64'h200 + 64'(k), (c < 7), lrd, ld,
          (c == 5), rdy, 1'b1);
      if (c < 7 && c != 5) k++;
    end
    idle(1'b1);
    idle(1'b1);

    // x0 targets: consumed without a write, never pending
    cyc(1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    check("t5_alu_x0_wen", 64'(bus.wen_o), 64'd1);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 64'h55, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 5'd0, 64'd0, 1'b1, 5'd20, 64'hC0FFEE, 1'b0, 1'b1, 1'b1);
    check("t5_x0_not_pending", 64'(bus.rd_pending_o), 64'd0);
    idle(1'b1);
    check("t5_lsu_x0_wen", 64'(bus.wen_o), 64'd1);
    check("t5_pending20", 64'(bus.rd_pending_o), 64'h0010_0000);
    idle(1'b1);
    check("t5_x20_wen", 64'(bus.wen_o), 64'd0);
    check("t5_x20_idx", 64'(bus.rd_idx_o), 64'd20);
    idle(1'b1);

    // asynchronous reset with two entries buffered
    mon_en = 1'b0;
    cyc(1'b1, 5'd3, 64'h300, 1'b1, 5'd21, 64'hD1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd3, 64'h301, 1'b1, 5'd22, 64'hD2, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 5'd3, 64'h302, 1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check("t6_pending_both", 64'(bus.rd_pending_o), 64'h0060_0000);
    check("t6_wen_pre", 64'(bus.wen_o), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_wen", 64'(bus.wen_o), 64'd1);
    check("t6_rst_pending", 64'(bus.rd_pending_o), 64'd0);
    check("t6_rst_ready", 64'(bus.lsu_ready_o), 64'd1);
    bus.alu_valid_i = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      idle(1'b1);
      check("t6_no_write", 64'(bus.wen_o), 64'd1);
    end

    check("alu_sb_drained", 64'(alu_q.size()), 64'd0);
    check("lsu_sb_drained", 64'(lsu_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
